// File: rtl/enemy_patrol_mover.sv
// enemy_patrol_mover: multi-slot horizontal patrol engine for walking enemies.
// Each slot is an independent IDLE/LEFT/RIGHT/SQUISH machine. Slots are spawned
// by a valid/ready handshake, killed by a stomp pulse, and turn around at solid
// tiles and at the play-field edges.
//
// Ports:
//   movement_clock  movement tick clock
//   reset           asynchronous active-low reset
//   background      tile map [row][col], one byte per tile
//   enemy_y         per-slot vertical position (owned by gravity logic)
//   spawn_valid/spawn_idx/spawn_x/spawn_dir  spawn request for one slot
//   spawn_ready     combinational: slot spawn_idx is IDLE
//   kill            per-slot stomp pulse
//   enemy_x         registered per-slot x position
//   enemy_alive / enemy_squished / enemy_dir  per-slot status
//
// Optional build macro ENEMY_LEDGE_TURN_EN: walking enemies also turn when the
// tile below their leading edge is SKY (ledge turnaround).
module enemy_patrol_mover #(
    parameter int NUM_ENEMIES     = 4,
    parameter int CHARACTER_WIDTH = 42,
    parameter int SCREEN_WIDTH    = 640,
    parameter int BLOCK_WIDTH     = 40,
    parameter int SPEED           = 1,
    parameter int SQUISH_TICKS    = 30,
    parameter int BLK             = 2,
    parameter int SKY             = 1,
    localparam int unsigned IDX_W = (NUM_ENEMIES > 1) ? $clog2(NUM_ENEMIES) : 1
) (
    input  logic                          movement_clock,
    input  logic                          reset,
    input  logic [11:0][16:0][7:0]        background,
    input  logic [NUM_ENEMIES-1:0][31:0]  enemy_y,
    input  logic                          spawn_valid,
    input  logic [IDX_W-1:0]              spawn_idx,
    input  logic [31:0]                   spawn_x,
    input  logic                          spawn_dir,
    output logic                          spawn_ready,
    input  logic [NUM_ENEMIES-1:0]        kill,
    output logic [NUM_ENEMIES-1:0][31:0]  enemy_x,
    output logic [NUM_ENEMIES-1:0]        enemy_alive,
    output logic [NUM_ENEMIES-1:0]        enemy_squished,
    output logic [NUM_ENEMIES-1:0]        enemy_dir
);

    localparam int unsigned CNT_W = $clog2(SQUISH_TICKS + 1);

    typedef enum logic [1:0] {S_IDLE, S_LEFT, S_RIGHT, S_SQUISH} state_t;

    state_t                              state_q [NUM_ENEMIES];
    state_t                              state_d [NUM_ENEMIES];
    logic [NUM_ENEMIES-1:0][31:0]        x_q, x_d;
    logic [NUM_ENEMIES-1:0][CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_ENEMIES-1:0]              turn_l, turn_r;

    // Pixel -> tile column, clamped to the map
    function automatic logic [4:0] col_of(input logic signed [31:0] p);
        logic signed [31:0] q;
        q = (p < 0) ? 32'sd0 : p / BLOCK_WIDTH;
        col_of = (q > 16) ? 5'd16 : 5'(q);
    endfunction

    // Pixel -> tile row, clamped to the map
    function automatic logic [3:0] row_of(input logic signed [31:0] p);
        logic signed [31:0] q;
        q = (p < 0) ? 32'sd0 : p / BLOCK_WIDTH;
        row_of = (q > 11) ? 4'd11 : 4'(q);
    endfunction

    // Per-slot turnaround detection from the current position
    for (genvar g = 0; g < NUM_ENEMIES; g++) begin : g_slot
        logic signed [31:0] x, y;
        logic [3:0]         top_row, bot_row;
        logic [4:0]         col_l, col_r;
        logic               stop_l, stop_r;

        assign x       = $signed(x_q[g]);
        assign y       = $signed(enemy_y[g]);
        assign top_row = row_of(y);
        assign bot_row = row_of(y + CHARACTER_WIDTH - 1);
        assign col_l   = (x < SPEED) ? 5'd0 : col_of(x - SPEED);
        assign col_r   = col_of(x + CHARACTER_WIDTH - 1 + SPEED);

        assign stop_l = (background[top_row][col_l] == 8'(BLK)) ||
                        (background[bot_row][col_l] == 8'(BLK)) ||
                        (x - SPEED < 0);
        assign stop_r = (background[top_row][col_r] == 8'(BLK)) ||
                        (background[bot_row][col_r] == 8'(BLK)) ||
                        (x + CHARACTER_WIDTH + SPEED > SCREEN_WIDTH);

`ifdef ENEMY_LEDGE_TURN_EN
        // No floor row exists below the bottom map row, so no ledge check there
        logic       has_floor;
        logic [3:0] below_row;
        assign has_floor = (bot_row != 4'd11);
        assign below_row = has_floor ? bot_row + 4'd1 : bot_row;
        assign turn_l[g] = stop_l || (has_floor && background[below_row][col_l] == 8'(SKY));
        assign turn_r[g] = stop_r || (has_floor && background[below_row][col_r] == 8'(SKY));
`else
        assign turn_l[g] = stop_l;
        assign turn_r[g] = stop_r;
`endif
    end

    // State register
    always_ff @(posedge movement_clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_ENEMIES; i++) begin
                state_q[i] <= S_IDLE;
            end
            x_q   <= '0;
            cnt_q <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: kill beats movement; a turn holds x for one tick
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        cnt_d   = cnt_q;
        for (int i = 0; i < NUM_ENEMIES; i++) begin
            case (state_q[i])
                S_IDLE: begin
                    if (spawn_valid && spawn_idx == IDX_W'(i)) begin
                        x_d[i]     = spawn_x;
                        state_d[i] = spawn_dir ? S_RIGHT : S_LEFT;
                    end
                end
                S_LEFT: begin
                    if (kill[i]) begin
                        state_d[i] = S_SQUISH;
                        cnt_d[i]   = CNT_W'(SQUISH_TICKS - 1);
                    end else if (turn_l[i]) begin
                        state_d[i] = S_RIGHT;
                    end else begin
                        x_d[i] = x_q[i] - 32'(SPEED);
                    end
                end
                S_RIGHT: begin
                    if (kill[i]) begin
                        state_d[i] = S_SQUISH;
                        cnt_d[i]   = CNT_W'(SQUISH_TICKS - 1);
                    end else if (turn_r[i]) begin
                        state_d[i] = S_LEFT;
                    end else begin
                        x_d[i] = x_q[i] + 32'(SPEED);
                    end
                end
                S_SQUISH: begin
                    if (cnt_q[i] == '0) begin
                        state_d[i] = S_IDLE;
                    end else begin
                        cnt_d[i] = cnt_q[i] - CNT_W'(1);
                    end
                end
                default: state_d[i] = S_IDLE;
            endcase
        end
    end

    // Output decode from registered state
    always_comb begin
        enemy_alive    = '0;
        enemy_squished = '0;
        enemy_dir      = '0;
        spawn_ready    = 1'b0;
        for (int i = 0; i < NUM_ENEMIES; i++) begin
            enemy_alive[i]    = (state_q[i] == S_LEFT) || (state_q[i] == S_RIGHT);
            enemy_squished[i] = (state_q[i] == S_SQUISH);
            enemy_dir[i]      = (state_q[i] == S_RIGHT);
            if (spawn_idx == IDX_W'(i) && state_q[i] == S_IDLE) begin
                spawn_ready = 1'b1;
            end
        end
    end

    assign enemy_x = x_q;

endmodule

// File: tb/tb_enemy_patrol_mover.sv
// Self-checking bench for enemy_patrol_mover (default parameters, SPEED=1).
module tb_enemy_patrol_mover;

    logic                   movement_clock;
    logic                   reset;
    logic [11:0][16:0][7:0] background;
    logic [3:0][31:0]       enemy_y;
    logic                   spawn_valid;
    logic [1:0]             spawn_idx;
    logic [31:0]            spawn_x;
    logic                   spawn_dir;
    logic                   spawn_ready;
    logic [3:0]             kill;
    logic [3:0][31:0]       enemy_x;
    logic [3:0]             enemy_alive;
    logic [3:0]             enemy_squished;
    logic [3:0]             enemy_dir;

    int tests;
    int failed;

    enemy_patrol_mover dut (
        .movement_clock (movement_clock),
        .reset          (reset),
        .background     (background),
        .enemy_y        (enemy_y),
        .spawn_valid    (spawn_valid),
        .spawn_idx      (spawn_idx),
        .spawn_x        (spawn_x),
        .spawn_dir      (spawn_dir),
        .spawn_ready    (spawn_ready),
        .kill           (kill),
        .enemy_x        (enemy_x),
        .enemy_alive    (enemy_alive),
        .enemy_squished (enemy_squished),
        .enemy_dir      (enemy_dir)
    );

    initial movement_clock = 1'b0;
    always #5 movement_clock = ~movement_clock;

    typedef struct {
        logic       sv;
        int         sidx;
        int         sx;
        logic       sdir;
        logic [3:0] kl;
        int         slot;
        int         ex;
        logic       ea;
        logic       es;
        logic       ed;
        logic       er;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge movement_clock);
        #1;
    endtask

    task automatic check_slot(input string name, input int s, input int ex,
                              input int ea, input int es, input int ed);
        check({name, "_x"},     int'(enemy_x[s]), ex);
        check({name, "_alive"}, int'(enemy_alive[s]), ea);
        check({name, "_sq"},    int'(enemy_squished[s]), es);
        check({name, "_dir"},   int'(enemy_dir[s]), ed);
    endtask

    task automatic do_spawn(input int s, input int x, input logic d);
        spawn_valid = 1'b1;
        spawn_idx   = 2'(s);
        spawn_x     = 32'(x);
        spawn_dir   = d;
        tick();
        spawn_valid = 1'b0;
    endtask

    task automatic clear_map();
        for (int r = 0; r < 12; r++)
            for (int c = 0; c < 17; c++)
                background[r][c] = 8'd1;
    endtask

    task automatic do_reset();
        @(negedge movement_clock);
        reset = 1'b0;
        @(negedge movement_clock);
        reset = 1'b1;
        tick();
    endtask

    initial begin
        int  cnt;
        logic frozen;

        //            sv  idx  x    dir  kill     slot ex   a     s     d     rdy
        vecs[0]  = '{1'b1, 1, 100, 1'b1, 4'b0000, 1, 100, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 1,   0, 1'b0, 4'b0000, 1, 101, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 1,   0, 1'b0, 4'b0000, 1, 102, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1,   0, 1'b0, 4'b0000, 1, 103, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1,   0, 1'b0, 4'b0010, 1, 103, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1,   7, 1'b0, 4'b0000, 1, 103, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 3,   2, 1'b0, 4'b0000, 3,   2, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 3,   0, 1'b0, 4'b0000, 3,   1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 3,   0, 1'b0, 4'b0000, 3,   0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 3,   0, 1'b0, 4'b0000, 3,   0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 3,   0, 1'b0, 4'b0000, 3,   1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 0, 300, 1'b1, 4'b0001, 0, 300, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 2,   0, 1'b0, 4'b0000, 0, 301, 1'b1, 1'b0, 1'b1, 1'b1};

        tests = 0;
        failed = 0;
        reset = 1'b0;
        spawn_valid = 1'b0;
        spawn_idx = '0;
        spawn_x = '0;
        spawn_dir = 1'b0;
        kill = '0;
        clear_map();
        for (int i = 0; i < 4; i++) enemy_y[i] = 32'd400;

        #12;
        check_slot("reset0", 0, 0, 0, 0, 0);
        reset = 1'b1;
        tick();

        // Table-driven spawn / walk / kill / left-edge vectors
        for (int v = 0; v < 13; v++) begin
            spawn_valid = vecs[v].sv;
            spawn_idx   = 2'(vecs[v].sidx);
            spawn_x     = 32'(vecs[v].sx);
            spawn_dir   = vecs[v].sdir;
            kill        = vecs[v].kl;
            tick();
            check_slot($sformatf("vec%0d", v), vecs[v].slot, vecs[v].ex,
                       int'(vecs[v].ea), int'(vecs[v].es), int'(vecs[v].ed));
            check($sformatf("vec%0d_ready", v), int'(spawn_ready), int'(vecs[v].er));
            spawn_valid = 1'b0;
            kill = '0;
        end

        // Squish lifetime on slot 2 with a rejected spawn mid-squish
        do_spawn(2, 400, 1'b1);
        check_slot("sq_spawn", 2, 400, 1, 0, 1);
        kill = 4'b0100;
        tick();
        kill = '0;
        cnt = 0;
        frozen = 1'b1;
        for (int t = 0; t < 35; t++) begin
            if (enemy_squished[2]) begin
                cnt++;
                if (enemy_x[2] != 32'd400) frozen = 1'b0;
            end
            if (t == 5) begin
                spawn_valid = 1'b1;
                spawn_idx = 2'd2;
                spawn_x = 32'd9;
                spawn_dir = 1'b0;
                #1;
                check("sq_ready_low", int'(spawn_ready), 0);
            end
            tick();
            spawn_valid = 1'b0;
        end
        check("sq_ticks", cnt, 30);
        check("sq_frozen", int'(frozen), 1);
        spawn_idx = 2'd2;
        #1;
        check_slot("sq_done", 2, 400, 0, 0, 0);
        check("sq_ready_high", int'(spawn_ready), 1);

        // Asynchronous reset while slots are walking
        tick();
        #2;
        reset = 1'b0;
        #1;
        for (int s = 0; s < 4; s++) begin
            spawn_idx = 2'(s);
            #1;
            check_slot($sformatf("arst%0d", s), s, 0, 0, 0, 0);
            check($sformatf("arst%0d_ready", s), int'(spawn_ready), 1);
        end
        @(negedge movement_clock);
        reset = 1'b1;
        tick();

        // Right screen edge: 598+42+1 > 640 triggers the turnaround tick
        do_spawn(0, 596, 1'b1);
        check_slot("edge0", 0, 596, 1, 0, 1);
        tick(); check_slot("edge1", 0, 597, 1, 0, 1);
        tick(); check_slot("edge2", 0, 598, 1, 0, 1);
        tick(); check_slot("edge3", 0, 598, 1, 0, 0);
        tick(); check_slot("edge4", 0, 597, 1, 0, 0);

        // Block at column 5 (x 200..239): lead edge x+42 reaches 200 at x=158
        background[10][5] = 8'd2;
        background[11][5] = 8'd2;
        do_spawn(1, 150, 1'b1);
        check_slot("blk0", 1, 150, 1, 0, 1);
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("blk_walk%0d", k), int'(enemy_x[1]), 150 + k);
        end
        tick(); check_slot("blk_turn", 1, 158, 1, 0, 0);
        tick(); check_slot("blk_back", 1, 157, 1, 0, 0);

        // Boxed in between columns 3 and 5: toggles direction, x fixed
        background[10][3] = 8'd2;
        background[11][3] = 8'd2;
        do_spawn(2, 158, 1'b1);
        check_slot("box0", 2, 158, 1, 0, 1);
        for (int t = 0; t < 4; t++) begin
            tick();
            check_slot($sformatf("box%0d", t + 1), 2, 158, 1, 0, (t % 2 == 0) ? 0 : 1);
        end

        // Ledge: floor row 10 solid only up to column 8, slot 3 rows 8..9
        do_reset();
        clear_map();
        for (int c = 0; c <= 8; c++) background[10][c] = 8'd2;
        enemy_y[3] = 32'd320;
        do_spawn(3, 315, 1'b1);
        check_slot("ledge0", 3, 315, 1, 0, 1);
        tick(); check("ledge1_x", int'(enemy_x[3]), 316);
        tick(); check("ledge2_x", int'(enemy_x[3]), 317);
        tick(); check("ledge3_x", int'(enemy_x[3]), 318);
`ifdef ENEMY_LEDGE_TURN_EN
        tick(); check_slot("ledge4", 3, 318, 1, 0, 0);
        tick(); check_slot("ledge5", 3, 317, 1, 0, 0);
`else
        tick(); check_slot("ledge4", 3, 319, 1, 0, 1);
        tick(); check_slot("ledge5", 3, 320, 1, 0, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
